// File: rtl/event_challenge_handler_if.sv
// Signal bundle between the game controller and the event challenge handler:
// phase, trigger and key inputs plus the registered event status outputs.
interface event_challenge_handler_if;
    logic [2:0] current_state;
    logic       trig_ev1;
    logic       trig_ev2;
    logic       key_ev1;
    logic       key_ev2;
    logic       event_active;
    logic [1:0] event_type;
    logic [4:0] time_left;
    logic       ev_success;
    logic       ev_fail;

    modport master (
        output current_state, trig_ev1, trig_ev2, key_ev1, key_ev2,
        input  event_active, event_type, time_left, ev_success, ev_fail
    );

    modport slave (
        input  current_state, trig_ev1, trig_ev2, key_ev1, key_ev2,
        output event_active, event_type, time_left, ev_success, ev_fail
    );
endinterface

// File: rtl/event_challenge_handler.sv
// Timed two-key challenge: a trigger starts a countdown, the matching key edge wins,
// a wrong key or expiry loses, and the verdict is shown for a fixed hold time.
module event_challenge_handler #(
    parameter int unsigned CYCLES_PER_SEC = 50_000_000,
    parameter int unsigned TIMEOUT_SEC    = 10,
    parameter int unsigned HOLD_CYCLES    = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    event_challenge_handler_if.slave  ev_if
);

    localparam int unsigned SEC_W  = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [SEC_W-1:0]  SEC_LAST     = SEC_W'(CYCLES_PER_SEC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]        TIMEOUT_INIT = 5'(TIMEOUT_SEC);

    localparam logic [1:0] TYPE_NONE = 2'd0;
    localparam logic [1:0] TYPE_EV1  = 2'd1;
    localparam logic [1:0] TYPE_EV2  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RESULT
    } state_e;

    state_e              state_q,    state_d;
    logic [SEC_W-1:0]    sec_cnt_q,  sec_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [4:0]          time_left_q, time_left_d;
    logic [1:0]          type_q,     type_d;
    logic                active_q,   active_d;
    logic                success_q,  success_d;
    logic                fail_q,     fail_d;
    logic                key1_prev_q, key1_prev_d;
    logic                key2_prev_q, key2_prev_d;

    logic phase_ok;
    logic edge1;
    logic edge2;
    logic any_edge;
    logic correct_edge;
    logic sec_wrap;
    logic timeout;

    assign phase_ok = (ev_if.current_state == 3'd1) ||
                      (ev_if.current_state == 3'd3) ||
                      (ev_if.current_state == 3'd4);

    // Key history tracks every cycle, so a key already held at event start never shows an edge.
    assign edge1    = ev_if.key_ev1 & ~key1_prev_q;
    assign edge2    = ev_if.key_ev2 & ~key2_prev_q;
    assign any_edge = edge1 | edge2;

    assign correct_edge = (type_q == TYPE_EV1) ? (edge1 & ~edge2) : (edge2 & ~edge1);

    assign sec_wrap = (sec_cnt_q == SEC_LAST);
    assign timeout  = sec_wrap && (time_left_q == 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sec_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            time_left_q <= '0;
            type_q      <= TYPE_NONE;
            active_q    <= 1'b0;
            success_q   <= 1'b0;
            fail_q      <= 1'b0;
            key1_prev_q <= 1'b0;
            key2_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_cnt_q   <= sec_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            time_left_q <= time_left_d;
            type_q      <= type_d;
            active_q    <= active_d;
            success_q   <= success_d;
            fail_q      <= fail_d;
            key1_prev_q <= key1_prev_d;
            key2_prev_q <= key2_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sec_cnt_d   = sec_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        time_left_d = time_left_q;
        type_d      = type_q;
        active_d    = active_q;
        success_d   = 1'b0;
        fail_d      = 1'b0;
        key1_prev_d = ev_if.key_ev1;
        key2_prev_d = ev_if.key_ev2;

        unique case (state_q)
            S_IDLE: begin
                if (phase_ok && (ev_if.trig_ev1 || ev_if.trig_ev2)) begin
                    state_d     = S_ACTIVE;
                    active_d    = 1'b1;
                    type_d      = ev_if.trig_ev1 ? TYPE_EV1 : TYPE_EV2;
                    time_left_d = TIMEOUT_INIT;
                    sec_cnt_d   = '0;
                end
            end

            S_ACTIVE: begin
                // Abort outranks any key edge in the same cycle: no verdict is given.
                if (!phase_ok) begin
                    state_d     = S_IDLE;
                    active_d    = 1'b0;
                    type_d      = TYPE_NONE;
                    time_left_d = '0;
                    sec_cnt_d   = '0;
                end else if (any_edge || timeout) begin
                    state_d     = S_RESULT;
                    time_left_d = '0;
                    hold_cnt_d  = '0;
                    success_d   = correct_edge;
                    fail_d      = ~correct_edge;
                end else if (sec_wrap) begin
                    sec_cnt_d   = '0;
                    time_left_d = time_left_q - 5'd1;
                end else begin
                    sec_cnt_d   = sec_cnt_q + SEC_W'(1);
                end
            end

            S_RESULT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                    type_d   = TYPE_NONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ev_if.event_active = active_q;
    assign ev_if.event_type   = type_q;
    assign ev_if.time_left    = time_left_q;
    assign ev_if.ev_success   = success_q;
    assign ev_if.ev_fail      = fail_q;

endmodule

// File: doc/event_challenge_handler.md
EVENT_CHALLENGE_HANDLER -- requirements
Module: event_challenge_handler

Interface
REQ-001 Parameter CYCLES_PER_SEC, default 50_000_000, clock cycles per displayed second.
REQ-002 Parameter TIMEOUT_SEC, default 10, seconds allowed per event (1..31).
REQ-003 Parameter HOLD_CYCLES, default 25_000_000, cycles the result state is held (>=1).
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 current_state  input  3  game phase; events are allowed only in phases 1, 3 and 4.
REQ-007 trig_ev1  input  1  single-cycle Event 1 request pulse.
REQ-008 trig_ev2  input  1  single-cycle Event 2 request pulse.
REQ-009 key_ev1  input  1  debounced level of the Event 1 response key.
REQ-010 key_ev2  input  1  debounced level of the Event 2 response key.
REQ-011 event_active  output  1  high from event start until the result hold ends.
REQ-012 event_type  output  2  0 = none, 1 = Event 1, 2 = Event 2.
REQ-013 time_left  output  5  whole seconds remaining; 0 outside ACTIVE.
REQ-014 ev_success  output  1  single-cycle pulse on a correct response.
REQ-015 ev_fail  output  1  single-cycle pulse on a wrong key or timeout.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, ACTIVE and RESULT, and all outputs SHALL be registered.
REQ-017 In IDLE, a trigger sampled while current_state is 1, 3 or 4 SHALL enter ACTIVE on the next edge; event_active=1, event_type is latched, time_left=TIMEOUT_SEC and the second counter=0 (1-cycle latency).
REQ-018 If trig_ev1 and trig_ev2 are sampled together, Event 1 SHALL win.
REQ-019 Triggers outside IDLE, or in any other phase, SHALL be ignored with no state change.
REQ-020 Key presses SHALL be rising edges detected against a previous-value register that updates every cycle in all states.
- A key already held when ACTIVE is entered SHALL NOT count.
REQ-021 In ACTIVE, the second counter SHALL increment every cycle.
- At CYCLES_PER_SEC-1 it SHALL wrap to 0 and decrement time_left.
REQ-022 Timeout SHALL occur when the counter wraps with time_left==1, giving exactly TIMEOUT_SEC*CYCLES_PER_SEC cycles in ACTIVE.
REQ-023 A correct-key edge alone (key_ev1 for type 1, key_ev2 for type 2) SHALL pulse ev_success and enter RESULT.
REQ-024 A wrong-key edge, or both key edges in the same cycle, SHALL pulse ev_fail and enter RESULT.
REQ-025 Timeout with no key edge SHALL pulse ev_fail and enter RESULT.
REQ-026 A correct-key edge in the timeout cycle SHALL count as success.
REQ-027 Key edges outside ACTIVE SHALL be ignored.
REQ-028 On entry to RESULT, time_left SHALL be 0 and event_active and event_type SHALL be held.
- After HOLD_CYCLES cycles in RESULT, the FSM SHALL return to IDLE with event_active=0 and event_type=0.
REQ-029 If current_state leaves {1,3,4} during ACTIVE, the FSM SHALL abort to IDLE on the next edge with no result pulse.
- A phase change during RESULT SHALL NOT shorten the hold.
REQ-030 ev_success and ev_fail SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.

Reset
REQ-031 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
- event_active=0, event_type=0, time_left=0, ev_success=0, ev_fail=0.
- Both counters and both key-history registers SHALL clear.
REQ-032 Reset asserted mid-event SHALL discard the event with no result pulse.
REQ-033 Reset SHALL have no asynchronous effect.

Verification (CYCLES_PER_SEC=4, TIMEOUT_SEC=3, HOLD_CYCLES=2)
REQ-034 Scenario 1: phase=1, trig_ev1 at cycle 0, key_ev1 rises at cycle 5.
- event_active=1 and event_type=1 from cycle 1.
- time_left goes 3 -> 2 at the first wrap.
- ev_success for one cycle, then event_active=0 two cycles later.
REQ-035 Scenario 2: phase=3, trig_ev2, no keys.
- ev_fail exactly 12 cycles after entering ACTIVE.
- time_left sequence 3, 2, 1, then 0 in RESULT.
REQ-036 Scenario 3: phase=4, trig_ev1 and trig_ev2 together -> event_type=1; a later key_ev2 edge -> ev_fail.
REQ-037 Scenario 4: phase=2, trig_ev1 -> no response, event_active stays 0.
- Second trigger while ACTIVE -> ignored.
REQ-038 Scenario 5: key_ev1 held high before trig_ev1 -> no success.
- Release, then re-press -> ev_success.
REQ-039 Scenario 6: phase changes 1 -> 0 during ACTIVE -> IDLE the next cycle, no pulse.
- rst_n=0 mid-ACTIVE -> all outputs 0 at the next edge.
